instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries; SHALL be a power of two and at least 2.
REQ-002 Port: clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: load_iq_fetch  input  1  enqueue request from fetch.
REQ-005 Port: pc_in  input  32  PC of the incoming instruction.
REQ-006 Port: instr_in  input  32  instruction word returned by the I-cache.
REQ-007 Port: flush_iq_fetch  input  1  discard all entries (mispredict or halt).
REQ-008 Port: iq_really_full  output  1  high when count == DEPTH.
REQ-009 Port: iq_empty  output  1  high when count == 0.
REQ-010 Port: deq_valid  output  1  head entry available.
REQ-011 Port: deq_pc  output  32  head PC.
REQ-012 Port: deq_instr  output  32  head instruction.
REQ-013 Port: deq_ready  input  1  consumer takes the head this cycle.
REQ-014 Port: iq_count  output  $clog2(DEPTH)+1  occupancy.
REQ-015 Port: iq_overflow  output  1  sticky error flag.

Function
REQ-016 Storage SHALL be a circular buffer: a write pointer and a read pointer, each $clog2(DEPTH) bits, both wrapping from DEPTH-1 to 0.
REQ-017 Enqueue SHALL be accepted iff load_iq_fetch && !iq_really_full && !flush_iq_fetch; when accepted, {pc_in, instr_in} is written at wptr and wptr increments.
REQ-018 iq_really_full SHALL be decoded from the registered count; a same-cycle dequeue SHALL NOT make room for a same-cycle enqueue.
REQ-019 load_iq_fetch while iq_really_full SHALL drop the data, leave state unchanged and set iq_overflow, which holds until rst.
REQ-020 Dequeue SHALL be accepted iff deq_valid && deq_ready && !flush_iq_fetch; rptr then increments.
REQ-021 Dequeue with deq_valid low SHALL be ignored (no underflow, no pointer change).
REQ-022 Count SHALL change by +1 for an enqueue alone, by -1 for a dequeue alone, and by 0 for both at once; it SHALL never exceed DEPTH or go below 0.
REQ-023 Without bypass, deq_valid = !iq_empty and deq_pc/deq_instr = mem[rptr]; a written entry is visible one cycle after its enqueue.
REQ-024 flush_iq_fetch SHALL take priority over enqueue and dequeue in the same cycle and SHALL set wptr=0, rptr=0 and count=0 on the next edge; iq_overflow is unaffected.
REQ-025 While flush_iq_fetch is high, deq_valid SHALL be forced to 0.
REQ-026 Holding flush for multiple cycles SHALL keep the queue empty.
REQ-027 Entry contents SHALL NOT require reset; only pointers, count and flags are reset.

Reset
REQ-028 rst SHALL dominate flush, enqueue and dequeue.
REQ-029 After rst: wptr=0, rptr=0, iq_count=0, iq_empty=1, iq_really_full=0, deq_valid=0, iq_overflow=0.
REQ-030 rst asserted mid-operation SHALL discard all entries within the same edge.

Configuration
REQ-031 Macro IQ_BYPASS_EN: when defined, if iq_empty && load_iq_fetch && !flush_iq_fetch:
  - deq_valid SHALL be 1 in that cycle, with deq_pc=pc_in and deq_instr=instr_in;
  - if deq_ready is also 1, the entry is consumed without being stored and count stays 0;
  - otherwise the entry is stored as normal.
REQ-032 When IQ_BYPASS_EN is undefined, REQ-023 latency applies and there is no combinational path from the enqueue inputs to the deq outputs.

Verification
REQ-033 Fill test:
  - Stimulus: rst, then 8 enqueues with pc 0x60,0x64,...,0x7C and deq_ready=0.
  - Response: iq_really_full=1 and iq_count=8 after the 8th edge.
  - Then 8 dequeues with deq_ready=1 return pc 0x60..0x7C in order, and iq_empty=1 afterwards.
REQ-034 Overflow test:
  - Stimulus: while full, load_iq_fetch=1 with pc 0x80.
  - Response: iq_count stays 8, iq_overflow=1, and the head remains 0x60.
REQ-035 Wrap-around test:
  - Stimulus: 5 enqueues, 5 dequeues, then 6 enqueues with pc 0x100..0x114.
  - Response: dequeue order is 0x100..0x114, with correct data across the pointer wrap.
REQ-036 Flush-priority test:
  - Stimulus: count=3, then load_iq_fetch=1, deq_ready=1 and flush_iq_fetch=1 in the same cycle.
  - Response: next cycle iq_count=0, iq_empty=1, deq_valid=0, and the incoming entry is lost.
REQ-037 Simultaneous-operation test:
  - Stimulus: count=4, enqueue and dequeue in the same cycle.
  - Response: count stays 4 and the head advances by one.
  - With count=8 plus enqueue and dequeue together: count becomes 7 and the enqueue is dropped with iq_overflow=1.
REQ-038 Bypass test:
  - Stimulus: empty queue, load_iq_fetch=1, pc_in=0x200, deq_ready=1.
  - With IQ_BYPASS_EN: deq_valid=1 and deq_pc=0x200 in the same cycle, and count stays 0.
  - Without IQ_BYPASS_EN: deq_valid=0 that cycle, then deq_valid=1 with deq_pc=0x200 next cycle.

Source files
------------

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, instr} pairs.
// Optional same-cycle bypass of an empty queue when IQ_BYPASS_EN is defined.
module instr_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_iq_fetch,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic                     flush_iq_fetch,
    output logic                     iq_really_full,
    output logic                     iq_empty,
    output logic                     deq_valid,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_instr,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   iq_count,
    output logic                     iq_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 64;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enq;
    logic          deq;
    logic [DW-1:0] head;
    logic          bypass_hit;

    assign iq_count       = count;
    assign iq_overflow    = overflow;
    assign iq_empty       = (count == CW'(0));
    assign iq_really_full = (count == CW'(DEPTH));
    assign head           = mem[rptr];

`ifdef IQ_BYPASS_EN
    // Empty queue forwards the fetch payload straight to the consumer.
    assign bypass_hit = iq_empty && load_iq_fetch && !flush_iq_fetch;
`else
    assign bypass_hit = 1'b0;
`endif

    assign deq_valid = !flush_iq_fetch && (!iq_empty || bypass_hit);
    assign deq_pc    = bypass_hit ? pc_in    : head[DW-1:32];
    assign deq_instr = bypass_hit ? instr_in : head[31:0];

    // Full is taken from the registered count, so a dequeue never frees a slot for the same cycle.
    assign enq = load_iq_fetch && !iq_really_full && !flush_iq_fetch;
    assign deq = deq_valid && deq_ready && !flush_iq_fetch;

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem[wptr] <= {pc_in, instr_in};
        end
    end

    // A bypassed-and-consumed entry advances both pointers, leaving count at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_iq_fetch) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + AW'(1);
            end
            if (deq) begin
                rptr <= rptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky until reset; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (load_iq_fetch && iq_really_full) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=8); expectations follow IQ_BYPASS_EN.
module tb_instr_queue;

    logic        clk;
    logic        rst;
    logic        load_iq_fetch;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        flush_iq_fetch;
    logic        iq_really_full;
    logic        iq_empty;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_ready;
    logic [3:0]  iq_count;
    logic        iq_overflow;

    int total;
    int bad;

    instr_queue #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_iq_fetch  (load_iq_fetch),
        .pc_in          (pc_in),
        .instr_in       (instr_in),
        .flush_iq_fetch (flush_iq_fetch),
        .iq_really_full (iq_really_full),
        .iq_empty       (iq_empty),
        .deq_valid      (deq_valid),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .deq_ready      (deq_ready),
        .iq_count       (iq_count),
        .iq_overflow    (iq_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_iq_fetch  = 1'b0;
        deq_ready      = 1'b0;
        flush_iq_fetch = 1'b0;
    endtask

    task automatic enq_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            load_iq_fetch = 1'b1;
            pc_in         = base + 32'(4 * i);
            instr_in      = ins_of(base + 32'(4 * i));
            step();
        end
        load_iq_fetch = 1'b0;
    endtask

    task automatic deq_chk(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(deq_valid), 32'd1);
            chk({tag, "_pc"}, deq_pc, base + 32'(4 * i));
            chk({tag, "_instr"}, deq_instr, ins_of(base + 32'(4 * i)));
            deq_ready = 1'b1;
            step();
        end
        deq_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        pc_in    = '0;
        instr_in = '0;
        rst      = 1'b1;
        #1;
        do_reset();

        chk("rst_count", 32'(iq_count), 32'd0);
        chk("rst_empty", 32'(iq_empty), 32'd1);
        chk("rst_full", 32'(iq_really_full), 32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_ovf", 32'(iq_overflow), 32'd0);

        // Fill
        enq_n(32'h60, 8);
        chk("fill_full", 32'(iq_really_full), 32'd1);
        chk("fill_count", 32'(iq_count), 32'd8);
        chk("fill_head", deq_pc, 32'h60);

        // Overflow while full
        load_iq_fetch = 1'b1;
        pc_in         = 32'h80;
        instr_in      = ins_of(32'h80);
        step();
        load_iq_fetch = 1'b0;
        chk("ovf_count", 32'(iq_count), 32'd8);
        chk("ovf_flag", 32'(iq_overflow), 32'd1);
        chk("ovf_head", deq_pc, 32'h60);

        // Drain in order
        deq_chk("drain", 32'h60, 8);
        chk("drain_empty", 32'(iq_empty), 32'd1);
        chk("drain_valid", 32'(deq_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(iq_overflow), 32'd1);

        // Dequeue on empty is ignored
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("underflow_count", 32'(iq_count), 32'd0);

        // Wrap-around
        enq_n(32'h300, 5);
        deq_chk("pre_wrap", 32'h300, 5);
        enq_n(32'h100, 6);
        chk("wrap_count", 32'(iq_count), 32'd6);
        deq_chk("wrap", 32'h100, 6);
        chk("wrap_empty", 32'(iq_empty), 32'd1);

        // Flush priority over enqueue and dequeue
        enq_n(32'h400, 3);
        chk("flush_pre_count", 32'(iq_count), 32'd3);
        load_iq_fetch  = 1'b1;
        deq_ready      = 1'b1;
        flush_iq_fetch = 1'b1;
        pc_in          = 32'h500;
        instr_in       = ins_of(32'h500);
        #1;
        chk("flush_valid_forced", 32'(deq_valid), 32'd0);
        step();
        idle_inputs();
        chk("flush_count", 32'(iq_count), 32'd0);
        chk("flush_empty", 32'(iq_empty), 32'd1);
        chk("flush_valid", 32'(deq_valid), 32'd0);
        step();
        chk("flush_lost", 32'(iq_count), 32'd0);
        chk("flush_ovf_kept", 32'(iq_overflow), 32'd1);

        // Multi-cycle flush with enqueue attempts
        flush_iq_fetch = 1'b1;
        load_iq_fetch  = 1'b1;
        step();
        step();
        idle_inputs();
        chk("flush2_count", 32'(iq_count), 32'd0);

        // Reset mid-operation dominates a pending enqueue
        enq_n(32'h900, 2);
        rst           = 1'b1;
        load_iq_fetch = 1'b1;
        pc_in         = 32'h980;
        step();
        rst           = 1'b0;
        load_iq_fetch = 1'b0;
        chk("midrst_count", 32'(iq_count), 32'd0);
        chk("midrst_empty", 32'(iq_empty), 32'd1);
        chk("midrst_ovf", 32'(iq_overflow), 32'd0);

        // Simultaneous enqueue/dequeue at count 4
        enq_n(32'h600, 4);
        load_iq_fetch = 1'b1;
        deq_ready     = 1'b1;
        pc_in         = 32'h610;
        instr_in      = ins_of(32'h610);
        step();
        idle_inputs();
        chk("simul_count", 32'(iq_count), 32'd4);
        chk("simul_head", deq_pc, 32'h604);

        // Simultaneous at full: dequeue wins a slot, enqueue dropped
        enq_n(32'h614, 4);
        chk("simfull_pre_count", 32'(iq_count), 32'd8);
        chk("simfull_pre_ovf", 32'(iq_overflow), 32'd0);
        load_iq_fetch = 1'b1;
        deq_ready     = 1'b1;
        pc_in         = 32'h700;
        instr_in      = ins_of(32'h700);
        step();
        idle_inputs();
        chk("simfull_count", 32'(iq_count), 32'd7);
        chk("simfull_ovf", 32'(iq_overflow), 32'd1);
        chk("simfull_head", deq_pc, 32'h608);
        deq_chk("simfull_rest", 32'h608, 7);
        chk("simfull_empty", 32'(iq_empty), 32'd1);

        // Bypass behaviour on an empty queue
        do_reset();
        load_iq_fetch = 1'b1;
        deq_ready     = 1'b1;
        pc_in         = 32'h200;
        instr_in      = ins_of(32'h200);
        #1;
`ifdef IQ_BYPASS_EN
        chk("byp_valid", 32'(deq_valid), 32'd1);
        chk("byp_pc", deq_pc, 32'h200);
        chk("byp_instr", deq_instr, ins_of(32'h200));
        step();
        idle_inputs();
        chk("byp_count", 32'(iq_count), 32'd0);
        chk("byp_empty", 32'(iq_empty), 32'd1);
`else
        chk("nobyp_valid0", 32'(deq_valid), 32'd0);
        step();
        idle_inputs();
        chk("nobyp_valid1", 32'(deq_valid), 32'd1);
        chk("nobyp_pc", deq_pc, 32'h200);
        chk("nobyp_count", 32'(iq_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
